truth_table_extractor: RTL and testbench

//  Sequential reader for combinational truth-table gates (case-table modules such as 3-input logic cells).

---
 rtl/tt_pkg.sv | 18 +
 rtl/tt_settle_timer.sv | 30 +++
 rtl/truth_table_extractor.sv | 134 +++++++++++++
 tb/tb_truth_table_extractor.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table extractor: FSM states and the row-count function.
// Pure declarations; no logic, no latency.
package tt_pkg;

  localparam int MAX_N_IN = 6;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  function automatic int rows(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Loadable down-counter that times how long each input vector is held before sampling.
// Zero flag is combinational from the count; load has priority over decrement; no backpressure.
module tt_settle_timer #(
  parameter int SETTLE_CYC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [W-1:0] RELOAD = W'(SETTLE_CYC - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/truth_table_extractor.sv
// Sweeps every input vector of a gate, samples its output after a settle delay and builds the table.
// done fires ROWS*(SETTLE_CYC+1)+1 cycles after start is accepted; start is ignored while busy.
module truth_table_extractor
  import tt_pkg::*;
#(
  parameter int N_IN = 3,
  parameter int SETTLE_CYC = 2,
  localparam int ROWS = rows(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [ROWS-1:0] expect_tt,
  output logic [N_IN-1:0] fn_in,
  input  logic            fn_out,
  output logic            busy,
  output logic            done,
  output logic [ROWS-1:0] tt,
  output logic            tt_valid,
  output logic            match,
  output logic [N_IN-1:0] first_miss
);

  localparam logic [N_IN:0] LAST_ROW = (N_IN + 1)'(ROWS - 1);

  state_t          state;
  state_t          state_nxt;
  logic [N_IN:0]   row;
  logic [N_IN-1:0] row_idx;
  logic [ROWS-1:0] exp_q;
  logic            miss_seen;
  logic            last_row;
  logic            timer_load;
  logic            timer_dec;
  logic            timer_zero;

  assign row_idx  = row[N_IN-1:0];
  assign last_row = (row == LAST_ROW);

  tt_settle_timer #(
    .SETTLE_CYC(SETTLE_CYC)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(timer_load),
    .dec (timer_dec),
    .zero(timer_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt  = SETTLE;
          timer_load = 1'b1;
        end
      end
      SETTLE: begin
        timer_dec = 1'b1;
        if (timer_zero) begin
          state_nxt = SAMPLE;
        end
      end
      SAMPLE: begin
        if (last_row) begin
          state_nxt = DONE;
        end else begin
          state_nxt  = SETTLE;
          timer_load = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The row counter only advances on SAMPLE->SETTLE, so fn_in is never disturbed mid-row.
  always_ff @(posedge clk) begin
    if (rst) begin
      row        <= '0;
      tt         <= '0;
      exp_q      <= '0;
      tt_valid   <= 1'b0;
      match      <= 1'b0;
      first_miss <= '0;
      miss_seen  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row        <= '0;
            tt         <= '0;
            tt_valid   <= 1'b0;
            exp_q      <= expect_tt;
            first_miss <= '0;
            miss_seen  <= 1'b0;
          end
        end
        SAMPLE: begin
          tt[row_idx] <= fn_out;
          if ((fn_out != exp_q[row_idx]) && !miss_seen) begin
            first_miss <= row_idx;
            miss_seen  <= 1'b1;
          end
          if (!last_row) begin
            row <= row + (N_IN + 1)'(1);
          end
        end
        DONE: begin
          tt_valid <= 1'b1;
          match    <= (tt == exp_q);
        end
        default: begin
        end
      endcase
    end
  end

  assign fn_in = row_idx;
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_truth_table_extractor.sv
// Scoreboard bench: three extractor configurations driven by directed sweeps, checked by a done-driven monitor.
module tb_truth_table_extractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: N_IN=3, SETTLE_CYC=2
  logic       start_a, busy_a, done_a, vld_a, match_a, fn_out_a;
  logic [7:0] exp_a, tt_a;
  logic [2:0] fn_in_a, miss_a;
  // Instance B: N_IN=3, SETTLE_CYC=1
  logic       start_b, busy_b, done_b, vld_b, match_b, fn_out_b;
  logic [7:0] exp_b, tt_b;
  logic [2:0] fn_in_b, miss_b;
  // Instance C: N_IN=1, SETTLE_CYC=1
  logic       start_c, busy_c, done_c, vld_c, match_c, fn_out_c;
  logic [1:0] exp_c, tt_c;
  logic [0:0] fn_in_c, miss_c;

  truth_table_extractor #(.N_IN(3), .SETTLE_CYC(2)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .expect_tt(exp_a), .fn_in(fn_in_a), .fn_out(fn_out_a),
    .busy(busy_a), .done(done_a), .tt(tt_a), .tt_valid(vld_a), .match(match_a), .first_miss(miss_a)
  );
  truth_table_extractor #(.N_IN(3), .SETTLE_CYC(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .expect_tt(exp_b), .fn_in(fn_in_b), .fn_out(fn_out_b),
    .busy(busy_b), .done(done_b), .tt(tt_b), .tt_valid(vld_b), .match(match_b), .first_miss(miss_b)
  );
  truth_table_extractor #(.N_IN(1), .SETTLE_CYC(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .expect_tt(exp_c), .fn_in(fn_in_c), .fn_out(fn_out_c),
    .busy(busy_c), .done(done_c), .tt(tt_c), .tt_valid(vld_c), .match(match_c), .first_miss(miss_c)
  );

  // Gate models. The delayed variant is a registered gate behind a registered input, two flops deep.
  logic [7:0] tbl_a = 8'h9C;
  logic [7:0] tbl_b = 8'h9C;
  logic       dly_mode_a = 1'b0;
  logic [1:0] pipe_a = 2'b00;
  logic [1:0] pipe_b = 2'b00;
  always @(posedge clk) begin
    pipe_a <= {pipe_a[0], tbl_a[fn_in_a]};
    pipe_b <= {pipe_b[0], tbl_b[fn_in_b]};
  end
  assign fn_out_a = dly_mode_a ? pipe_a[1] : tbl_a[fn_in_a];
  assign fn_out_b = pipe_b[1];
  assign fn_out_c = ~fn_in_c[0];

  typedef struct {
    int         id;
    int         acc;
    int         lat;
    logic [7:0] tt;
    logic       m;
    logic [2:0] miss;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  int         mon_id = 0;
  logic [7:0] m_tt;
  logic [2:0] m_miss;
  logic       m_done, m_vld, m_match;
  always_comb begin
    m_tt = tt_a; m_miss = miss_a; m_done = done_a; m_vld = vld_a; m_match = match_a;
    if (mon_id == 1) begin
      m_tt = tt_b; m_miss = miss_b; m_done = done_b; m_vld = vld_b; m_match = match_b;
    end else if (mon_id == 2) begin
      m_tt = {6'b0, tt_c}; m_miss = {2'b0, miss_c}; m_done = done_c; m_vld = vld_c; m_match = match_c;
    end
  end

  initial begin : monitor
    exp_t e;
    int   id;
    forever begin
      @(negedge clk);
      if (!rst && (done_a || done_b || done_c)) begin
        id = done_a ? 0 : (done_b ? 1 : 2);
        if (sb.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL unexpected_done: instance %0d pulsed done with nothing pending (cycle %0d)", id, cyc);
        end else begin
          e = sb.pop_front();
          mon_id = id;
          chk("done_source", id, e.id);
          chk("done_latency", cyc - e.acc, e.lat);
          @(negedge clk);
          chk("done_one_cycle", m_done, 0);
          chk("tt_valid", m_vld, 1);
          chk("tt", m_tt, e.tt);
          chk("match", m_match, e.m);
          chk("first_miss", m_miss, e.miss);
        end
      end
    end
  end

  task automatic issue(input int id, input logic [7:0] expv, input int lat,
                       input logic [7:0] ett, input logic em, input logic [2:0] emiss);
    exp_t e;
    @(negedge clk);
    if (id == 0) begin start_a = 1'b1; exp_a = expv; end
    else if (id == 1) begin start_b = 1'b1; exp_b = expv; end
    else begin start_c = 1'b1; exp_c = expv[1:0]; end
    e.id = id; e.acc = cyc; e.lat = lat; e.tt = ett; e.m = em; e.miss = emiss;
    sb.push_back(e);
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_fn_a(input logic [2:0] v);
    int n = 0;
    while (fn_in_a !== v && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_fn_in", fn_in_a, v);
  endtask

  task automatic chk_reset_a();
    chk("rst_fn_in", fn_in_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_tt", tt_a, 0);
    chk("rst_tt_valid", vld_a, 0);
    chk("rst_match", match_a, 0);
    chk("rst_first_miss", miss_a, 0);
  endtask

  initial begin : stim
    exp_t e;
    int   acc;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    exp_a = '0; exp_b = '0; exp_c = '0;
    repeat (3) @(negedge clk);
    chk_reset_a();
    chk("rst_c_tt", tt_c, 0);
    rst = 1'b0;

    // Reference gate, matching expectation
    issue(0, 8'h9C, 25, 8'h9C, 1'b1, 3'd0);
    drain();
    // AND3 against the reference expectation
    tbl_a = 8'h80;
    issue(0, 8'h9C, 25, 8'h80, 1'b0, 3'd2);
    drain();
    // Delayed gate: one settle cycle reads the previous row's answer, two settle cycles are enough
    issue(1, 8'h9C, 17, 8'h38, 1'b0, 3'd2);
    drain();
    tbl_a = 8'h9C;
    dly_mode_a = 1'b1;
    issue(0, 8'h9C, 25, 8'h9C, 1'b1, 3'd0);
    drain();
    dly_mode_a = 1'b0;

    // Reset during row 4 of a sweep that has already recorded a miss
    @(negedge clk);
    start_a = 1'b1; exp_a = 8'h00;
    @(negedge clk);
    start_a = 1'b0;
    wait_fn_a(3'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_a();
    issue(0, 8'h9C, 25, 8'h9C, 1'b1, 3'd0);
    drain();

    // Start pulses during a running sweep are ignored
    tbl_a = 8'h80;
    issue(0, 8'h80, 25, 8'h80, 1'b1, 3'd0);
    wait_fn_a(3'd1);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_fn_a(3'd6);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    drain();

    // start held high: second sweep accepted in the IDLE cycle right after DONE
    tbl_a = 8'h9C;
    @(negedge clk);
    start_a = 1'b1; exp_a = 8'h9C; acc = cyc;
    e.id = 0; e.acc = acc; e.lat = 25; e.tt = 8'h9C; e.m = 1'b1; e.miss = 3'd0;
    sb.push_back(e);
    e.acc = acc + 26;
    sb.push_back(e);
    while (cyc < acc + 27) @(negedge clk);
    chk("b2b_tt_valid_drop", vld_a, 0);
    chk("b2b_busy", busy_a, 1);
    start_a = 1'b0;
    drain();

    // One-input inverter
    issue(2, 8'h01, 5, 8'h01, 1'b1, 3'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
